// File: rtl/tulip_dsp_pkg.sv
// Shared types and widths for the tulip DSP programming path.
// Holds the sequencer state/phase encodings and the sample/tap widths.
package tulip_dsp_pkg;

  localparam int C_ADC_DWIDTH           = 24;
  localparam int C_USER_FILT_TAP_DWIDTH = 16;

  typedef logic [31:0] float_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FLUSH,
    S_LUT,
    S_LUT_W,
    S_FIR,
    S_FIR_W,
    S_IIRB,
    S_IIRB_W,
    S_IIRA,
    S_IIRA_W,
    S_RUN,
    S_ERROR
  } prog_state_t;

  typedef enum logic [1:0] {
    PH_LUT  = 2'd0,
    PH_FIR  = 2'd1,
    PH_IIRB = 2'd2,
    PH_IIRA = 2'd3
  } prog_phase_t;

  // Bits needed to hold 0..count-1, never less than one bit.
  function automatic int clog2_min1(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/tulip_dsp_prog_sequencer_phase_counter.sv
// Word counter and wait counter shared by all programming phases.
// Strobes fire in the cycle the final word is accepted / the wait limit is hit.
module prog_phase_counter #(
  parameter int G_WORD_W = 8,
  parameter int G_WAIT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                word_inc,
  input  logic [G_WORD_W-1:0] word_last_idx,
  input  logic                wait_inc,
  input  logic [G_WAIT_W-1:0] wait_limit_m1,
  output logic                last_word,
  output logic                timeout
);

  logic [G_WORD_W-1:0] word_cnt_reg;
  logic [G_WAIT_W-1:0] wait_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else if (clr) begin
      word_cnt_reg <= '0;
      wait_cnt_reg <= '0;
    end else begin
      if (word_inc) word_cnt_reg <= word_cnt_reg + G_WORD_W'(1);
      if (wait_inc) wait_cnt_reg <= wait_cnt_reg + G_WAIT_W'(1);
    end
  end

  assign last_word = word_inc && (word_cnt_reg == word_last_idx);
  assign timeout   = wait_inc && (wait_cnt_reg == wait_limit_m1);

endmodule

// File: rtl/tulip_dsp_prog_sequencer.sv
// Steers one config stream into the LUT, FIR, IIR-b and IIR-a loaders in turn,
// waits for each loader's done flag, then releases bypass so audio flows.
module tulip_dsp_prog_sequencer
  import tulip_dsp_pkg::*;
#(
  parameter int G_LUT_AWIDTH   = 10,
  parameter int G_NUM_FIR_TAPS = 129,
  parameter int G_IIR_DEGREE   = 3,
  parameter int G_FLUSH_CYCLES = 4,
  parameter int G_DONE_TIMEOUT = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              abort,
  input  logic [31:0]                       cfg_din,
  input  logic                              cfg_din_valid,
  output logic                              cfg_din_ready,
  output logic [C_ADC_DWIDTH-1:0]           lut_prog_din,
  output logic                              lut_prog_valid,
  input  logic                              lut_prog_ready,
  input  logic                              lut_prog_done,
  output logic [C_USER_FILT_TAP_DWIDTH-1:0] fir_prog_din,
  output logic                              fir_prog_valid,
  input  logic                              fir_prog_ready,
  input  logic                              fir_prog_done,
  output float_t                            iir_b_din,
  output logic                              iir_b_valid,
  input  logic                              iir_b_ready,
  input  logic                              iir_b_done,
  output float_t                            iir_a_din,
  output logic                              iir_a_valid,
  input  logic                              iir_a_ready,
  input  logic                              iir_a_done,
  output logic                              dsp_enable,
  output logic                              dsp_bypass,
  output logic                              busy,
  output logic                              running,
  output logic                              error,
  output logic [1:0]                        err_phase
);

  localparam int N_LUT    = 1 << G_LUT_AWIDTH;
  localparam int N_MAX0   = (N_LUT > G_NUM_FIR_TAPS) ? N_LUT : G_NUM_FIR_TAPS;
  localparam int N_MAX    = (N_MAX0 > G_IIR_DEGREE) ? N_MAX0 : G_IIR_DEGREE;
  localparam int WORD_W   = clog2_min1(N_MAX);
  localparam int WAIT_MAX = (G_FLUSH_CYCLES > G_DONE_TIMEOUT) ? G_FLUSH_CYCLES : G_DONE_TIMEOUT;
  localparam int WAIT_W   = clog2_min1(WAIT_MAX);

  prog_state_t state_reg, state_next;
  prog_phase_t err_phase_reg, err_phase_next;
  logic        dsp_enable_reg, dsp_bypass_reg;
  logic        enable_next, bypass_next;

  logic              word_inc, wait_inc, in_wait, clr;
  logic              last_word, timeout;
  logic [WORD_W-1:0] word_last_idx;
  logic [WAIT_W-1:0] wait_limit_m1;

  assign lut_prog_din = cfg_din[C_ADC_DWIDTH-1:0];
  assign fir_prog_din = cfg_din[C_USER_FILT_TAP_DWIDTH-1:0];
  assign iir_b_din    = cfg_din;
  assign iir_a_din    = cfg_din;

  // Zero-latency steering; abort kills the handshake so no word is half-taken.
  always_comb begin
    cfg_din_ready  = 1'b0;
    lut_prog_valid = 1'b0;
    fir_prog_valid = 1'b0;
    iir_b_valid    = 1'b0;
    iir_a_valid    = 1'b0;
    if (!abort) begin
      case (state_reg)
        S_LUT:   begin lut_prog_valid = cfg_din_valid; cfg_din_ready = lut_prog_ready; end
        S_FIR:   begin fir_prog_valid = cfg_din_valid; cfg_din_ready = fir_prog_ready; end
        S_IIRB:  begin iir_b_valid    = cfg_din_valid; cfg_din_ready = iir_b_ready;    end
        S_IIRA:  begin iir_a_valid    = cfg_din_valid; cfg_din_ready = iir_a_ready;    end
        default: ;
      endcase
    end
  end

  always_comb begin
    word_last_idx = '0;
    case (state_reg)
      S_LUT:         word_last_idx = WORD_W'(N_LUT - 1);
      S_FIR:         word_last_idx = WORD_W'(G_NUM_FIR_TAPS - 1);
      S_IIRB, S_IIRA: word_last_idx = WORD_W'(G_IIR_DEGREE - 1);
      default:       ;
    endcase
  end

  assign word_inc      = cfg_din_valid && cfg_din_ready;
  assign in_wait       = state_reg inside {S_LUT_W, S_FIR_W, S_IIRB_W, S_IIRA_W};
  assign wait_inc      = in_wait || (state_reg == S_FLUSH);
  assign wait_limit_m1 = (state_reg == S_FLUSH) ? WAIT_W'(G_FLUSH_CYCLES - 1)
                                                : WAIT_W'(G_DONE_TIMEOUT - 1);

  always_comb begin
    state_next     = state_reg;
    err_phase_next = err_phase_reg;
    case (state_reg)
      S_IDLE, S_RUN, S_ERROR:
        if (start) begin
          state_next     = S_FLUSH;
          err_phase_next = PH_LUT;
        end
      S_FLUSH: if (timeout)   state_next = S_LUT;
      S_LUT:   if (last_word) state_next = S_LUT_W;
      S_FIR:   if (last_word) state_next = S_FIR_W;
      S_IIRB:  if (last_word) state_next = S_IIRB_W;
      S_IIRA:  if (last_word) state_next = S_IIRA_W;
      S_LUT_W:
        if (lut_prog_done) state_next = S_FIR;
        else if (timeout) begin state_next = S_ERROR; err_phase_next = PH_LUT; end
      S_FIR_W:
        if (fir_prog_done) state_next = S_IIRB;
        else if (timeout) begin state_next = S_ERROR; err_phase_next = PH_FIR; end
      S_IIRB_W:
        if (iir_b_done) state_next = S_IIRA;
        else if (timeout) begin state_next = S_ERROR; err_phase_next = PH_IIRB; end
      S_IIRA_W:
        if (iir_a_done) state_next = S_RUN;
        else if (timeout) begin state_next = S_ERROR; err_phase_next = PH_IIRA; end
      default: state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next     = S_IDLE;
      err_phase_next = PH_LUT;
    end
  end

  // Every state change starts its phase with fresh counters.
  assign clr = abort || (state_next != state_reg);

  prog_phase_counter #(
    .G_WORD_W (WORD_W),
    .G_WAIT_W (WAIT_W)
  ) u_counter (
    .clk           (clk),
    .reset         (reset),
    .clr           (clr),
    .word_inc      (word_inc),
    .word_last_idx (word_last_idx),
    .wait_inc      (wait_inc),
    .wait_limit_m1 (wait_limit_m1),
    .last_word     (last_word),
    .timeout       (timeout)
  );

  assign enable_next = state_next inside {S_LUT, S_LUT_W, S_FIR, S_FIR_W, S_IIRB,
                                          S_IIRB_W, S_IIRA, S_IIRA_W, S_RUN};
  assign bypass_next = (state_next != S_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      err_phase_reg  <= PH_LUT;
      dsp_enable_reg <= 1'b0;
      dsp_bypass_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      err_phase_reg  <= err_phase_next;
      dsp_enable_reg <= enable_next;
      dsp_bypass_reg <= bypass_next;
    end
  end

  assign dsp_enable = dsp_enable_reg;
  assign dsp_bypass = dsp_bypass_reg;
  assign busy       = !(state_reg inside {S_IDLE, S_RUN, S_ERROR});
  assign running    = (state_reg == S_RUN);
  assign error      = (state_reg == S_ERROR);
  assign err_phase  = err_phase_reg;

endmodule

// File: tb/tb_tulip_dsp_prog_sequencer.sv
// Randomized bench for the programming sequencer: scoreboards every loader port
// against the generated config stream and checks timing of flush, timeout, abort and reset.
module tb_tulip_dsp_prog_sequencer;

  localparam int AW    = 4;
  localparam int NLUT  = 16;
  localparam int NFIR  = 5;
  localparam int DEG   = 3;
  localparam int FLUSH = 4;
  localparam int TMO   = 8;
  localparam int NTOT  = NLUT + NFIR + 2 * DEG;

  logic        clk, reset, start, abort;
  logic [31:0] cfg_din;
  logic        cfg_din_valid, cfg_din_ready;
  logic [23:0] lut_prog_din;
  logic        lut_prog_valid, lut_prog_ready, lut_prog_done;
  logic [15:0] fir_prog_din;
  logic        fir_prog_valid, fir_prog_ready, fir_prog_done;
  logic [31:0] iir_b_din, iir_a_din;
  logic        iir_b_valid, iir_b_ready, iir_b_done;
  logic        iir_a_valid, iir_a_ready, iir_a_done;
  logic        dsp_enable, dsp_bypass, busy, running, error;
  logic [1:0]  err_phase;

  logic [3:0]  done_vec;
  assign lut_prog_done = done_vec[0];
  assign fir_prog_done = done_vec[1];
  assign iir_b_done    = done_vec[2];
  assign iir_a_done    = done_vec[3];

  tulip_dsp_prog_sequencer #(
    .G_LUT_AWIDTH   (AW),
    .G_NUM_FIR_TAPS (NFIR),
    .G_IIR_DEGREE   (DEG),
    .G_FLUSH_CYCLES (FLUSH),
    .G_DONE_TIMEOUT (TMO)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .abort (abort),
    .cfg_din (cfg_din), .cfg_din_valid (cfg_din_valid), .cfg_din_ready (cfg_din_ready),
    .lut_prog_din (lut_prog_din), .lut_prog_valid (lut_prog_valid),
    .lut_prog_ready (lut_prog_ready), .lut_prog_done (lut_prog_done),
    .fir_prog_din (fir_prog_din), .fir_prog_valid (fir_prog_valid),
    .fir_prog_ready (fir_prog_ready), .fir_prog_done (fir_prog_done),
    .iir_b_din (iir_b_din), .iir_b_valid (iir_b_valid),
    .iir_b_ready (iir_b_ready), .iir_b_done (iir_b_done),
    .iir_a_din (iir_a_din), .iir_a_valid (iir_a_valid),
    .iir_a_ready (iir_a_ready), .iir_a_done (iir_a_done),
    .dsp_enable (dsp_enable), .dsp_bypass (dsp_bypass),
    .busy (busy), .running (running), .error (error), .err_phase (err_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] gen[$];
  logic [31:0] tx_q[$];
  logic [31:0] lut_rx[$], fir_rx[$], b_rx[$], a_rx[$];
  int  done_cnt[4];
  int  since_start = 0;
  bit  bp_mode = 0, hold_fir = 0, feed_en = 0, in_prog = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rx_size(input int which);
    case (which)
      0:       return lut_rx.size();
      1:       return fir_rx.size();
      2:       return b_rx.size();
      default: return a_rx.size();
    endcase
  endfunction

  // One clock: sample/check at negedge, then drive new inputs 1ns after posedge.
  task automatic step();
    @(negedge clk);
    if (start) since_start = 0;
    else if (since_start < 100000) since_start++;
    if (in_prog && !abort && reset) begin
      if (since_start >= 1 && since_start <= FLUSH) begin
        check_val("flush_enable", 32'(dsp_enable), 0);
        check_val("flush_bypass", 32'(dsp_bypass), 1);
        check_val("flush_ready", 32'(cfg_din_ready), 0);
      end
      if (since_start == FLUSH + 1)
        check_val("enable_after_flush", 32'(dsp_enable), 1);
      if (since_start > FLUSH && lut_rx.size() < NLUT) begin
        check_val("lut_ready_mirror", 32'(cfg_din_ready), 32'(lut_prog_ready));
        check_val("lut_valid_mirror", 32'(lut_prog_valid), 32'(cfg_din_valid));
        check_val("fir_valid_idle", 32'(fir_prog_valid), 0);
      end
    end
    if (cfg_din_valid && cfg_din_ready && tx_q.size() > 0) void'(tx_q.pop_front());
    if (lut_prog_valid && lut_prog_ready) begin
      lut_rx.push_back({8'h00, lut_prog_din});
      if (lut_rx.size() == NLUT) done_cnt[0] = 2;
    end
    if (fir_prog_valid && fir_prog_ready) begin
      fir_rx.push_back({16'h0000, fir_prog_din});
      if (fir_rx.size() == NFIR && !hold_fir) done_cnt[1] = 2;
    end
    if (iir_b_valid && iir_b_ready) begin
      b_rx.push_back(iir_b_din);
      if (b_rx.size() == DEG) done_cnt[2] = 2;
    end
    if (iir_a_valid && iir_a_ready) begin
      a_rx.push_back(iir_a_din);
      if (a_rx.size() == DEG) done_cnt[3] = 2;
    end
    @(posedge clk);
    #1;
    for (int t = 0; t < 4; t++) begin
      done_vec[t] = 1'b0;
      if (done_cnt[t] > 0) begin
        done_cnt[t]--;
        if (done_cnt[t] == 0) done_vec[t] = 1'b1;
      end
    end
    lut_prog_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    fir_prog_ready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    iir_b_ready    = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    iir_a_ready    = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    cfg_din_valid  = feed_en && (tx_q.size() > 0) && ($urandom_range(0, 4) != 0);
    cfg_din        = (tx_q.size() > 0) ? tx_q[0] : $urandom;
  endtask

  task automatic begin_program(input bit bp, input bit hold);
    logic [31:0] w;
    gen.delete(); tx_q.delete();
    lut_rx.delete(); fir_rx.delete(); b_rx.delete(); a_rx.delete();
    for (int t = 0; t < 4; t++) done_cnt[t] = 0;
    done_vec = 4'b0000;
    bp_mode  = bp;
    hold_fir = hold;
    for (int i = 0; i < NTOT; i++) begin
      w = $urandom;
      gen.push_back(w);
      tx_q.push_back(w);
    end
    feed_en = 1'b1;
    in_prog = 1'b1;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_count(input int which, input int n, input string tag);
    int k = 0;
    while (rx_size(which) < n && k < 500) begin
      step();
      k++;
    end
    check_val(tag, 32'(rx_size(which) >= n), 1);
  endtask

  task automatic finish_to_run(input string tag);
    wait_count(3, DEG, {tag, "_reach_iira"});
    repeat (4) step();
    check_val({tag, "_running"}, 32'(running), 1);
    check_val({tag, "_bypass"}, 32'(dsp_bypass), 0);
    check_val({tag, "_enable"}, 32'(dsp_enable), 1);
    check_val({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_data(input string tag);
    check_val({tag, "_lut_count"}, 32'(lut_rx.size()), NLUT);
    check_val({tag, "_fir_count"}, 32'(fir_rx.size()), NFIR);
    check_val({tag, "_b_count"}, 32'(b_rx.size()), DEG);
    check_val({tag, "_a_count"}, 32'(a_rx.size()), DEG);
    for (int i = 0; i < NLUT && i < lut_rx.size(); i++)
      check_val({tag, "_lut_word"}, lut_rx[i], {8'h00, gen[i][23:0]});
    for (int i = 0; i < NFIR && i < fir_rx.size(); i++)
      check_val({tag, "_fir_word"}, fir_rx[i], {16'h0000, gen[NLUT + i][15:0]});
    for (int i = 0; i < DEG && i < b_rx.size(); i++)
      check_val({tag, "_b_word"}, b_rx[i], gen[NLUT + NFIR + i]);
    for (int i = 0; i < DEG && i < a_rx.size(); i++)
      check_val({tag, "_a_word"}, a_rx[i], gen[NLUT + NFIR + DEG + i]);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_enable"}, 32'(dsp_enable), 0);
    check_val({tag, "_bypass"}, 32'(dsp_bypass), 1);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_running"}, 32'(running), 0);
    check_val({tag, "_error"}, 32'(error), 0);
    check_val({tag, "_err_phase"}, 32'(err_phase), 0);
    check_val({tag, "_cfg_ready"}, 32'(cfg_din_ready), 0);
    check_val({tag, "_valids"}, 32'({lut_prog_valid, fir_prog_valid, iir_b_valid, iir_a_valid}), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_din = 32'h0; cfg_din_valid = 1'b1;
    lut_prog_ready = 1'b1; fir_prog_ready = 1'b1; iir_b_ready = 1'b1; iir_a_ready = 1'b1;
    done_vec = 4'b0000;
    for (int t = 0; t < 4; t++) done_cnt[t] = 0;
    #23;
    check_reset_values("reset");
    reset = 1'b1;
    repeat (2) step();
    check_reset_values("idle_after_reset");

    // Happy path from IDLE, then an extra word must stall in RUN.
    begin_program(1'b0, 1'b0);
    finish_to_run("happy");
    check_data("happy");
    tx_q.push_back(32'hDEAD_BEEF);
    repeat (6) step();
    check_val("extra_word_stall_ready", 32'(cfg_din_ready), 0);
    check_val("extra_word_not_taken", 32'(tx_q.size()), 1);
    check_val("extra_word_no_a_tap", 32'(a_rx.size()), DEG);

    // Reprogram from RUN with random backpressure on every loader.
    begin_program(1'b1, 1'b0);
    finish_to_run("reprog_bp");
    check_data("reprog_bp");

    // FIR done withheld: exactly TMO cycles in FIR_W before ERROR.
    begin_program(1'b0, 1'b1);
    wait_count(1, NFIR, "tmo_reach_fir_w");
    repeat (TMO - 1) step();
    check_val("tmo_not_yet_error", 32'(error), 0);
    check_val("tmo_still_busy", 32'(busy), 1);
    step();
    check_val("tmo_error", 32'(error), 1);
    check_val("tmo_err_phase", 32'(err_phase), 1);
    check_val("tmo_enable", 32'(dsp_enable), 0);
    check_val("tmo_bypass", 32'(dsp_bypass), 1);
    check_val("tmo_no_b_taps", 32'(b_rx.size()), 0);

    // Start from ERROR clears error; abort after 7 LUT words.
    begin_program(1'b0, 1'b0);
    check_val("start_clears_error", 32'(error), 0);
    wait_count(0, 7, "abort_reach_7");
    abort = 1'b1;
    step();
    abort   = 1'b0;
    in_prog = 1'b0;
    feed_en = 1'b0;
    check_val("abort_idle", 32'(busy), 0);
    check_val("abort_cfg_ready", 32'(cfg_din_ready), 0);
    check_val("abort_enable", 32'(dsp_enable), 0);
    check_val("abort_bypass", 32'(dsp_bypass), 1);
    check_val("abort_lut_words", 32'(lut_rx.size()), 7);
    repeat (2) step();

    begin_program(1'b0, 1'b0);
    finish_to_run("reload");
    check_data("reload");

    // Asynchronous reset in the middle of the FIR phase.
    begin_program(1'b1, 1'b0);
    wait_count(1, 2, "rst_reach_fir");
    in_prog = 1'b0;
    feed_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (3) step();
    check_reset_values("after_async_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
